// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: field encodings, ALU codes
// and the ID/EX register bundle.
package decode_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [XLEN-1:0]    imm;
        logic               use_imm;
        logic [2:0]         alu_op;
        logic [RADDR_W-1:0] de;
        logic               we;
        logic               mem_rd;
        logic               mem_wr;
    } id_ex_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
        return {{(XLEN-16){1'b0}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_id_decoder.sv
// Combinational decoder for the supported MIPS subset.
// Unsupported encodings report legal=0 and never write.
module id_decoder
    import decode_stage_pkg::*;
(
    input  logic [XLEN-1:0]    instr,
    output logic [XLEN-1:0]    imm,
    output logic               use_imm,
    output logic [2:0]         alu_op,
    output logic [RADDR_W-1:0] de,
    output logic               we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               legal,
    output logic               uses_rt
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       is_nop;
    logic       is_r;

    assign op     = instr[31:26];
    assign fn     = instr[5:0];
    assign is_nop = (instr == '0);
    assign is_r   = (op == OP_RTYPE) && !is_nop;

    always_comb begin
        imm     = '0;
        use_imm = 1'b0;
        alu_op  = ALU_ADD;
        de      = '0;
        we      = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        legal   = 1'b0;
        uses_rt = 1'b0;
        unique case (1'b1)
            is_nop: begin
                legal = 1'b1;
            end
            is_r: begin
                de      = instr[15:11];
                uses_rt = 1'b1;
                legal   = 1'b1;
                case (fn)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            (op == OP_ADDI): begin
                imm     = sext16(instr[15:0]);
                use_imm = 1'b1;
                de      = instr[20:16];
                legal   = 1'b1;
            end
            (op == OP_ANDI): begin
                imm     = zext16(instr[15:0]);
                use_imm = 1'b1;
                alu_op  = ALU_AND;
                de      = instr[20:16];
                legal   = 1'b1;
            end
            (op == OP_ORI): begin
                imm     = zext16(instr[15:0]);
                use_imm = 1'b1;
                alu_op  = ALU_OR;
                de      = instr[20:16];
                legal   = 1'b1;
            end
            (op == OP_LW): begin
                imm     = sext16(instr[15:0]);
                use_imm = 1'b1;
                de      = instr[20:16];
                mem_rd  = 1'b1;
                legal   = 1'b1;
            end
            (op == OP_SW): begin
                imm     = sext16(instr[15:0]);
                use_imm = 1'b1;
                de      = instr[20:16];
                mem_wr  = 1'b1;
                uses_rt = 1'b1;
                legal   = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        // Stores carry rt as de only for bookkeeping; $0 is never written.
        we = legal && (de != '0) && !mem_wr;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID and ID/EX registers, register-file addressing,
// load-use stall and valid/ready handshake toward EX.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [XLEN-1:0]    if_instr,
    output logic               if_ready,
    input  logic               flush,
    output logic [RADDR_W-1:0] rf_dl1,
    output logic [RADDR_W-1:0] rf_dl2,
    input  logic [XLEN-1:0]    rf_op1,
    input  logic [XLEN-1:0]    rf_op2,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [XLEN-1:0]    ex_imm,
    output logic               ex_use_imm,
    output logic [2:0]         ex_alu_op,
    output logic [RADDR_W-1:0] ex_de,
    output logic               ex_we,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               illegal
);

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic            ex_valid_q, ex_valid_d;
    id_ex_t          ex_q, ex_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0]    dec_imm;
    logic               dec_use_imm;
    logic [2:0]         dec_alu_op;
    logic [RADDR_W-1:0] dec_de;
    logic               dec_we;
    logic               dec_mem_rd;
    logic               dec_mem_wr;
    logic               dec_legal;
    logic               dec_uses_rt;

    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic               ex_free;
    logic               hazard;
    logic               id_adv;

    id_decoder u_dec (
        .instr   (id_instr_q),
        .imm     (dec_imm),
        .use_imm (dec_use_imm),
        .alu_op  (dec_alu_op),
        .de      (dec_de),
        .we      (dec_we),
        .mem_rd  (dec_mem_rd),
        .mem_wr  (dec_mem_wr),
        .legal   (dec_legal),
        .uses_rt (dec_uses_rt)
    );

    assign rs     = id_instr_q[25:21];
    assign rt     = id_instr_q[20:16];
    assign rf_dl1 = rs;
    assign rf_dl2 = rt;

    // Only a load in EX is too late for forwarding; everything else bypasses.
    assign ex_free = !ex_valid_q || ex_ready;
    assign hazard  = id_valid_q && ex_valid_q && ex_q.mem_rd
                     && (ex_q.de != '0)
                     && ((ex_q.de == rs)
                         || ((ex_q.de == rt) && dec_uses_rt));
    assign id_adv  = id_valid_q && ex_free && !hazard;

    assign if_ready = !flush && (!id_valid_q || id_adv);

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (if_valid && if_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = if_instr;
        end else if (id_adv) begin
            id_valid_d = 1'b0;
        end
    end

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        illegal_d  = 1'b0;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_free) begin
            ex_valid_d = id_adv && dec_legal;
            illegal_d  = id_adv && !dec_legal;
            if (id_adv && dec_legal) begin
                ex_d.op1     = rf_op1;
                ex_d.op2     = rf_op2;
                ex_d.imm     = dec_imm;
                ex_d.use_imm = dec_use_imm;
                ex_d.alu_op  = dec_alu_op;
                ex_d.de      = dec_de;
                ex_d.we      = dec_we;
                ex_d.mem_rd  = dec_mem_rd;
                ex_d.mem_wr  = dec_mem_wr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            illegal_q  <= 1'b0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op1     = ex_q.op1;
    assign ex_op2     = ex_q.op2;
    assign ex_imm     = ex_q.imm;
    assign ex_use_imm = ex_q.use_imm;
    assign ex_alu_op  = ex_q.alu_op;
    assign ex_de      = ex_q.de;
    assign ex_we      = ex_q.we;
    assign ex_mem_rd  = ex_q.mem_rd;
    assign ex_mem_wr  = ex_q.mem_wr;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, expected
// EX bundles queued at issue and checked by an independent monitor.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic [4:0]  rf_dl1, rf_dl2;
    logic [31:0] rf_op1, rf_op2;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic        ex_use_imm;
    logic [2:0]  ex_alu_op;
    logic [4:0]  ex_de;
    logic        ex_we, ex_mem_rd, ex_mem_wr;
    logic        illegal;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic        use_imm;
        logic [2:0]  alu;
        logic [4:0]  de;
        logic        we;
        logic        rd;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   w;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .flush      (flush),
        .rf_dl1     (rf_dl1),
        .rf_dl2     (rf_dl2),
        .rf_op1     (rf_op1),
        .rf_op2     (rf_op2),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .ex_imm     (ex_imm),
        .ex_use_imm (ex_use_imm),
        .ex_alu_op  (ex_alu_op),
        .ex_de      (ex_de),
        .ex_we      (ex_we),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .illegal    (illegal)
    );

    // Register file contents: $0=0, $1=5, $2=7, others 0x1000+n.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == 5'd1) return 32'd5;
        if (a == 5'd2) return 32'd7;
        return 32'h1000 + {27'd0, a};
    endfunction

    assign rf_op1 = rf_val(rf_dl1);
    assign rf_op2 = rf_val(rf_dl2);

    function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [31:0] imm, input logic ui,
                                input logic [2:0] alu, input logic [4:0] de,
                                input logic we, input logic rd, input logic wr);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.imm = imm; e.use_imm = ui;
        e.alu = alu; e.de = de; e.we = we; e.rd = rd; e.wr = wr;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each EX handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            exp_t act;
            act = mk(ex_op1, ex_op2, ex_imm, ex_use_imm, ex_alu_op,
                     ex_de, ex_we, ex_mem_rd, ex_mem_wr);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL ex_out: unexpected issue got %h", act);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL ex_out: got %h expected %h", act, e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, output int waits);
        if_valid = 1'b1;
        if_instr = ins;
        waits = 0;
        @(negedge clk);
        while (!if_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 20) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got if_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        if_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD3  = 32'h00221820;
    localparam logic [31:0] I_LW4   = 32'h8C240000;
    localparam logic [31:0] I_ADD5  = 32'h00822820;
    localparam logic [31:0] I_ADDI6 = 32'h2006FFFF;
    localparam logic [31:0] I_ORI7  = 32'h3407FFFF;
    localparam logic [31:0] I_SUB8  = 32'h00224022;
    localparam logic [31:0] I_SLT9  = 32'h0041482A;
    localparam logic [31:0] I_ANDI  = 32'h302A8001;
    localparam logic [31:0] I_SW    = 32'hAC22FFFC;
    localparam logic [31:0] I_BADOP = 32'hFC000000;
    localparam logic [31:0] I_BADFN = 32'h00221821;
    localparam logic [31:0] I_ADD0  = 32'h00220020;

    exp_t e_add3, e_lw4, e_add5, e_sub8;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        e_add3 = mk(32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        e_lw4  = mk(32'd5, 32'h1004, 32'd0, 1'b1, 3'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        e_add5 = mk(32'h1004, 32'd7, 32'd0, 1'b0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        e_sub8 = mk(32'd5, 32'd7, 32'd0, 1'b0, 3'd1, 5'd8, 1'b1, 1'b0, 1'b0);

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0;
        if_instr = '0; ex_ready = 1'b1;
        #12;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_rf_dl", {22'd0, rf_dl1, rf_dl2}, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // back-to-back add, no stall
        sb.push_back(e_add3); send(I_ADD3, w);
        chk("t1_wait0", w, 0);
        sb.push_back(e_add3); send(I_ADD3, w);
        chk("t1_wait1", w, 0);
        drain();

        // load-use: one bubble then the consumer issues
        sb.push_back(e_lw4);  send(I_LW4, w);
        sb.push_back(e_add5); send(I_ADD5, w);
        if_valid = 1'b0;
        @(negedge clk);
        chk("t2_stall_ready", {31'd0, if_ready}, 32'd0);
        @(negedge clk);
        chk("t2_bubble", {31'd0, ex_valid}, 32'd0);
        chk("t2_ready_back", {31'd0, if_ready}, 32'd1);
        drain();

        // immediates and remaining opcodes
        sb.push_back(mk(32'd0, 32'h1006, 32'hFFFFFFFF, 1'b1, 3'd0, 5'd6, 1'b1, 1'b0, 1'b0));
        send(I_ADDI6, w);
        sb.push_back(mk(32'd0, 32'h1007, 32'h0000FFFF, 1'b1, 3'd3, 5'd7, 1'b1, 1'b0, 1'b0));
        send(I_ORI7, w);
        sb.push_back(e_sub8); send(I_SUB8, w);
        sb.push_back(mk(32'd7, 32'd5, 32'd0, 1'b0, 3'd4, 5'd9, 1'b1, 1'b0, 1'b0));
        send(I_SLT9, w);
        sb.push_back(mk(32'd5, 32'h100A, 32'h00008001, 1'b1, 3'd2, 5'd10, 1'b1, 1'b0, 1'b0));
        send(I_ANDI, w);
        sb.push_back(mk(32'd5, 32'd7, 32'hFFFFFFFC, 1'b1, 3'd0, 5'd2, 1'b0, 1'b0, 1'b1));
        send(I_SW, w);
        drain();

        // EX back-pressure for three cycles
        sb.push_back(e_add3); send(I_ADD3, w);
        ex_ready = 1'b0;
        sb.push_back(e_sub8); send(I_SUB8, w);
        chk("t4_fill", w, 0);
        if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, ex_valid}, 32'd1);
            chk("t4_hold_de", {27'd0, ex_de}, 32'd3);
            chk("t4_hold_op1", ex_op1, 32'd5);
            chk("t4_if_ready", {31'd0, if_ready}, 32'd0);
        end
        @(posedge clk); #1 ex_ready = 1'b1;
        drain();

        // illegal encodings and writes to $0
        send(I_BADOP, w);
        if_valid = 1'b0;
        @(negedge clk);
        chk("t5_ill_early", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("t5_ill_pulse", {31'd0, illegal}, 32'd1);
        chk("t5_ill_noissue", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);
        chk("t5_ill_once", {31'd0, illegal}, 32'd0);
        drain();
        send(I_BADFN, w);
        drain();
        sb.push_back(mk(32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        send(I_ADD0, w);
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        send(32'h00000000, w);
        drain();

        // flush during a load-use stall
        sb.push_back(e_lw4); send(I_LW4, w);
        send(I_ADD5, w);
        if_valid = 1'b0;
        @(negedge clk);
        chk("t6f_stall", {31'd0, if_ready}, 32'd0);
        #2 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("t6f_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("t6f_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("t6f_killed", {31'd0, ex_valid}, 32'd0);
        drain();

        // asynchronous reset during a load-use stall
        sb.push_back(e_lw4); send(I_LW4, w);
        send(I_ADD5, w);
        if_valid = 1'b0;
        @(negedge clk);
        chk("t6r_stall", {31'd0, if_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6r_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("t6r_illegal", {31'd0, illegal}, 32'd0);
        chk("t6r_rf_dl", {22'd0, rf_dl1, rf_dl2}, 32'd0);
        chk("t6r_if_ready", {31'd0, if_ready}, 32'd1);
        chk("t6r_ex_de", {27'd0, ex_de}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6r_killed", {31'd0, ex_valid}, 32'd0);
        end
        drain();

        sb.push_back(e_add3); send(I_ADD3, w);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
